dmem_ctrl: RTL and testbench

Data-memory access stage that sits directly downstream of `controller`. It consumes the controller's `rw`, `dfunc`, the ALU-computed effective address and store data (`dout`), and drives a word-wide data memory through a req/ack handshake. It returns aligned, sign- or zero-extended load data toward the controller's `din`. Sub-word stores are done as a read-modify-write sequence.

---
 rtl/dmem_pkg.sv | 46 ++++
 rtl/dmem_lane.sv | 44 ++++
 rtl/dmem_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access stage.
// Access-size codes, FSM states and dfunc decode helpers.
package dmem_pkg;

  localparam logic [2:0] DF_LB  = 3'b000;
  localparam logic [2:0] DF_LH  = 3'b001;
  localparam logic [2:0] DF_LW  = 3'b010;
  localparam logic [2:0] DF_LBU = 3'b100;
  localparam logic [2:0] DF_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } state_t;

  function automatic logic is_legal_dfunc(
    input logic [2:0] f
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      f == DF_LB:  ok = 1'b1;
      f == DF_LH:  ok = 1'b1;
      f == DF_LW:  ok = 1'b1;
      f == DF_LBU: ok = 1'b1;
      f == DF_LHU: ok = 1'b1;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] f,
    input logic [1:0] lo
  );
    return (f[1:0] == SZ_H && lo[0])
        || (f[1:0] == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: load extract/extend and store merge.
// Purely combinational; one instance serves both paths.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  dfunc,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mword
);

  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [4:0]  boff;

  assign boff = {lane, 3'b000};
  assign bsel = rword[boff +: 8];
  assign hsel = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ldata = rword;
    mword = rword;
    unique case (dfunc[1:0])
      SZ_B: begin
        ldata = dfunc[2] ? {24'b0, bsel}
                         : {{24{bsel[7]}}, bsel};
        mword[boff +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ldata = dfunc[2] ? {16'b0, hsel}
                         : {{16{hsel[15]}}, hsel};
        if (lane[1]) mword[31:16] = wdata[15:0];
        else         mword[15:0]  = wdata[15:0];
      end
      default: begin
        ldata = rword;
        mword = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access stage: req/ack word memory, RMW sub-word stores.
// Define DMEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_AW = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [2:0]        dfunc,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  state_t      state;
  state_t      nxt;
  logic        a_rw;
  logic [2:0]  a_dfunc;
  logic [1:0]  a_lane;
  logic [31:0] a_wdata;
  logic        err_q;
  logic        misal;
  logic        bad;
  logic        wstore;
  logic        accept;
  logic [31:0] ldata;
  logic [31:0] mword;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misal = is_misaligned(dfunc, addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign bad    = !is_legal_dfunc(dfunc) || misal;
  assign wstore = rw && dfunc[1:0] == SZ_W;
  assign accept = state == IDLE && req;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad)         nxt = FIN;
          else if (wstore) nxt = WR;
          else             nxt = RD;
        end
      end
      RD: if (mem_ack) nxt = a_rw ? WR : FIN;
      WR: if (mem_ack) nxt = FIN;
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rw      <= 1'b0;
      a_dfunc   <= 3'b0;
      a_lane    <= 2'b0;
      a_wdata   <= 32'b0;
      err_q     <= 1'b0;
      rdata     <= 32'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'b0;
    end else begin
      if (accept) begin
        a_rw     <= rw;
        a_dfunc  <= dfunc;
        a_lane   <= addr[1:0];
        a_wdata  <= wdata;
        err_q    <= bad;
        mem_addr <= addr[MEM_AW+1:2];
        if (wstore && !bad) mem_wdata <= wdata;
      end
      // Read half of the access: either finish a load or build the RMW word.
      if (state == RD && mem_ack) begin
        if (a_rw) mem_wdata <= mword;
        else      rdata     <= ldata;
      end
    end
  end

  dmem_lane u_lane (
    .dfunc (a_dfunc),
    .lane  (a_lane),
    .rword (mem_rdata),
    .wdata (a_wdata),
    .ldata (ldata),
    .mword (mword)
  );

  assign ready   = state == IDLE;
  assign mem_req = state == RD || state == WR;
  assign mem_we  = state == WR;
  assign done    = state == FIN && !err_q;
  assign err     = state == FIN && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus a
// randomized run against a byte-level memory reference model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [2:0]  dfunc = 3'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [29:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'b0;
  logic        mem_ack = 1'b0;

  int passed = 0;
  int total = 0;
  int ack_delay = 0;
  int cnt = 0;
  int mem_reads = 0;
  int mem_writes = 0;
  int fin_cyc;
  logic fin_err;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        obs_req [64];
  logic        obs_we [64];
  logic [29:0] obs_addr [64];
  logic [31:0] obs_wdata [64];

  dmem_ctrl #(.MEM_AW(30)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rw        (rw),
    .dfunc     (dfunc),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: each transfer is acked after ack_delay wait cycles.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (mem_req && !reset) begin
      if (cnt >= ack_delay) begin
        cnt = 0;
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr[5:0]];
        if (mem_we) begin
          mem[mem_addr[5:0]] = mem_wdata;
          mem_writes++;
        end else begin
          mem_reads++;
        end
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  function automatic logic ref_legal(input logic [2:0] f);
    return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int ref_bytes(input logic [2:0] f);
    if (f[1:0] == 2'b10) return 4;
    if (f[1:0] == 2'b01) return 2;
    return 1;
  endfunction

  function automatic logic ref_bad(
    input logic [2:0] f, input logic [31:0] a
  );
    logic mis;
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (a % ref_bytes(f)) != 0;
`endif
    return !ref_legal(f) || mis;
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [31:0] wd, input logic [2:0] f,
    input logic [31:0] a
  );
    int n;
    int sh;
    logic [31:0] v;
    n = ref_bytes(f);
    if (n == 4) return wd;
    sh = (n == 2) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
    v = (wd >> sh) & ((n == 2) ? 32'hFFFF : 32'hFF);
    if (!f[2] && n == 2 && v >= 32'h8000) v = v | 32'hFFFF0000;
    if (!f[2] && n == 1 && v >= 32'h80) v = v | 32'hFFFFFF00;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(
    input logic [31:0] old, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] w
  );
    int n;
    int sh;
    logic [31:0] m;
    n = ref_bytes(f);
    if (n == 4) return w;
    sh = (n == 2) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
    m = ((n == 2) ? 32'hFFFF : 32'hFF) << sh;
    return (old & ~m) | ((w << sh) & m);
  endfunction

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
  endtask

  task automatic run_op(
    input logic r, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] w, input int d
  );
    ack_delay = d;
    wait_idle();
    req = 1'b1; rw = r; dfunc = f; addr = a; wdata = w;
    @(posedge clk); #1;
    req = 1'b0; rw = 1'($urandom); dfunc = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    fin_cyc = 0;
    fin_err = 1'b0;
    for (int c = 1; c < 60; c++) begin
      obs_req[c] = mem_req;
      obs_we[c] = mem_we;
      obs_addr[c] = mem_addr;
      obs_wdata[c] = mem_wdata;
      if (done || err) begin
        fin_cyc = c;
        fin_err = err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ready, done, err, mem_req, mem_we} !== 5'b10000) begin
      $display("FAIL reset_ctl got=%b exp=10000",
               {ready, done, err, mem_req, mem_we});
    end else passed++;
    total++;
    if (rdata !== 32'b0) $display("FAIL reset_rdata got=%h exp=0", rdata);
    else passed++;
    total++;
    if (mem_addr !== 30'b0) $display("FAIL reset_maddr got=%h exp=0", mem_addr);
    else passed++;
    total++;
    if (mem_wdata !== 32'b0) $display("FAIL reset_mwdata got=%h exp=0", mem_wdata);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word_load();
    mem[4] = 32'hDEADBEEF;
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 0);
    total++;
    if ({obs_req[1], obs_we[1], obs_addr[1]} !== {2'b10, 30'h4}) begin
      $display("FAIL wl_mem got=%b/%b/%h exp=1/0/4",
               obs_req[1], obs_we[1], obs_addr[1]);
    end else passed++;
    total++;
    if (fin_cyc != 2 || fin_err !== 1'b0) begin
      $display("FAIL wl_done got=cyc%0d err%b exp=cyc2 err0", fin_cyc, fin_err);
    end else passed++;
    total++;
    if (rdata !== 32'hDEADBEEF) begin
      $display("FAIL wl_rdata got=%h exp=deadbeef", rdata);
    end else passed++;
  endtask

  task automatic test_byte_load();
    mem[4] = 32'h80112233;
    run_op(1'b0, 3'b000, 32'h13, 32'h0, 0);
    total++;
    if (rdata !== 32'hFFFFFF80 || fin_cyc != 2) begin
      $display("FAIL lb_signed got=%h cyc%0d exp=ffffff80 cyc2", rdata, fin_cyc);
    end else passed++;
    run_op(1'b0, 3'b100, 32'h13, 32'h0, 0);
    total++;
    if (rdata !== 32'h00000080) begin
      $display("FAIL lbu got=%h exp=00000080", rdata);
    end else passed++;
  endtask

  task automatic test_byte_store();
    mem[8] = 32'h11223344;
    run_op(1'b1, 3'b000, 32'h21, 32'h000000AB, 0);
    total++;
    if ({obs_req[1], obs_we[1], obs_req[2], obs_we[2]} !== 4'b1011) begin
      $display("FAIL sb_phases got=%b exp=1011",
               {obs_req[1], obs_we[1], obs_req[2], obs_we[2]});
    end else passed++;
    total++;
    if (obs_wdata[2] !== 32'h1122AB44 || mem[8] !== 32'h1122AB44) begin
      $display("FAIL sb_merge got=%h/%h exp=1122ab44", obs_wdata[2], mem[8]);
    end else passed++;
    total++;
    if (fin_cyc != 3 || rdata !== 32'h00000080) begin
      $display("FAIL sb_done got=cyc%0d rdata=%h exp=cyc3 00000080",
               fin_cyc, rdata);
    end else passed++;
  endtask

  task automatic test_misaligned();
    int r0;
    logic [31:0] prev;
    mem[0] = 32'hCAFE1234;
    r0 = mem_reads;
    prev = rdata;
    run_op(1'b0, 3'b001, 32'h3, 32'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    total++;
    if (fin_err !== 1'b1 || fin_cyc != 1 || obs_req[1] !== 1'b0) begin
      $display("FAIL mis_err got=err%b cyc%0d req%b exp=err1 cyc1 req0",
               fin_err, fin_cyc, obs_req[1]);
    end else passed++;
    total++;
    if (mem_reads != r0 || rdata !== prev) begin
      $display("FAIL mis_side got=reads%0d rdata=%h exp=reads%0d rdata=%h",
               mem_reads, rdata, r0, prev);
    end else passed++;
`else
    total++;
    if (fin_err !== 1'b0 || fin_cyc != 2) begin
      $display("FAIL mis_ok got=err%b cyc%0d exp=err0 cyc2", fin_err, fin_cyc);
    end else passed++;
    total++;
    if (rdata !== 32'hFFFFCAFE || mem_reads != r0 + 1) begin
      $display("FAIL mis_upper got=%h reads%0d exp=ffffcafe reads%0d",
               rdata, mem_reads, r0 + 1);
    end else passed++;
`endif
  endtask

  task automatic test_illegal();
    int r0;
    int w0;
    logic [31:0] prev;
    r0 = mem_reads;
    w0 = mem_writes;
    prev = rdata;
    run_op(1'b0, 3'b011, 32'h8, 32'h0, 0);
    total++;
    if (fin_err !== 1'b1 || fin_cyc != 1) begin
      $display("FAIL ill_ld got=err%b cyc%0d exp=err1 cyc1", fin_err, fin_cyc);
    end else passed++;
    run_op(1'b1, 3'b111, 32'h8, 32'h5A5A5A5A, 0);
    total++;
    if (fin_err !== 1'b1 || fin_cyc != 1) begin
      $display("FAIL ill_st got=err%b cyc%0d exp=err1 cyc1", fin_err, fin_cyc);
    end else passed++;
    total++;
    if (mem_reads != r0 || mem_writes != w0 || rdata !== prev) begin
      $display("FAIL ill_side got=r%0d w%0d %h exp=r%0d w%0d %h",
               mem_reads, mem_writes, rdata, r0, w0, prev);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    int r0;
    int w0;
    logic got;
    logic extra;
    mem[20] = 32'h0BADF00D;
    mem[24] = 32'h77777777;
    ack_delay = 3;
    wait_idle();
    r0 = mem_reads;
    w0 = mem_writes;
    req = 1'b1; rw = 1'b0; dfunc = 3'b010; addr = 32'h50;
    @(posedge clk); #1;
    rw = 1'b1; addr = 32'h60; wdata = 32'h12345678;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    extra = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_req || done) extra = 1'b1;
    end
    total++;
    if (got !== 1'b1 || rdata !== 32'h0BADF00D) begin
      $display("FAIL busy_first got=done%b rdata=%h exp=done1 0badf00d",
               got, rdata);
    end else passed++;
    total++;
    if (mem_reads != r0 + 1 || mem_writes != w0 || extra !== 1'b0
        || mem[24] !== 32'h77777777) begin
      $display("FAIL busy_drop got=r%0d w%0d x%b m%h exp=r%0d w%0d x0 m77777777",
               mem_reads, mem_writes, extra, mem[24], r0 + 1, w0);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    int w0;
    logic seen;
    logic act;
    mem[16] = 32'h01020304;
    ack_delay = 3;
    wait_idle();
    w0 = mem_writes;
    req = 1'b1; rw = 1'b1; dfunc = 3'b001;
    addr = 32'h42; wdata = 32'h5555BEEF;
    @(posedge clk); #1;
    req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (mem_ack) begin
        seen = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (seen !== 1'b1 || {ready, mem_req, done, err} !== 4'b1000) begin
      $display("FAIL rst_mid got=ack%b ctl=%b exp=ack1 ctl=1000",
               seen, {ready, mem_req, done, err});
    end else passed++;
    @(negedge clk);
    reset = 1'b0;
    act = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_req || done || err) act = 1'b1;
    end
    total++;
    if (act !== 1'b0 || mem_writes != w0 || mem[16] !== 32'h01020304) begin
      $display("FAIL rst_nowr got=act%b w%0d m=%h exp=act0 w%0d m=01020304",
               act, mem_writes, mem[16], w0);
    end else passed++;
  endtask

  task automatic test_random();
    logic        r;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] exp_rd;
    int d;
    int exp_cyc;
    int wi;
    logic b;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    exp_rd = rdata;
    for (int n = 0; n < 150; n++) begin
      r = 1'($urandom);
      f = 3'($urandom);
      a = $urandom_range(0, 255);
      w = $urandom;
      d = $urandom_range(0, 2);
      wi = int'(a >> 2);
      b = ref_bad(f, a);
      if (b) exp_cyc = 1;
      else if (!r || ref_bytes(f) == 4) exp_cyc = 2 + d;
      else exp_cyc = 3 + 2 * d;
      if (!b && !r) exp_rd = ref_load(ref_mem[wi], f, a);
      if (!b && r) ref_mem[wi] = ref_store(ref_mem[wi], f, a, w);
      run_op(r, f, a, w, d);
      total++;
      if (fin_err !== b || fin_cyc != exp_cyc) begin
        $display("FAIL rnd%0d_ctl got=err%b cyc%0d exp=err%b cyc%0d",
                 n, fin_err, fin_cyc, b, exp_cyc);
      end else passed++;
      total++;
      if (rdata !== exp_rd || mem[wi] !== ref_mem[wi]) begin
        $display("FAIL rnd%0d_data got=%h/%h exp=%h/%h",
                 n, rdata, mem[wi], exp_rd, ref_mem[wi]);
      end else passed++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'b0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_misaligned();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
